// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX stage bundle between the decode side (ID, hazard and branch
// units) and the ID/EX pipeline register.
//   ID side  : in_valid, stall, flush, opcode, funct3, funct7_5, rs1, rs2, rd,
//              rs1_data, rs2_data, imm, pc
//   EX side  : hazard (combinational), ex_valid, ex_a, ex_b, ex_op,
//              ex_store_data, ex_rd, ex_pc, ex_regwrite, ex_memread,
//              ex_memwrite, ex_beq, ex_bne, ex_illegal
//   Optional : bubble_cnt (present only when BUBBLE_CNT_EN is defined)
// Modports: master = decode side / environment, slave = id_ex_stage.
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;
  logic [RA_W-1:0] rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            hazard;
  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [2:0]      ex_op;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic [XLEN-1:0] ex_pc;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_beq;
  logic            ex_bne;
  logic            ex_illegal;
`ifdef BUBBLE_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  modport master (
    output in_valid, stall, flush, opcode, funct3, funct7_5, rs1, rs2, rd,
           rs1_data, rs2_data, imm, pc,
    input  hazard, ex_valid, ex_a, ex_b, ex_op, ex_store_data, ex_rd, ex_pc,
           ex_regwrite, ex_memread, ex_memwrite, ex_beq, ex_bne, ex_illegal
`ifdef BUBBLE_CNT_EN
    , input bubble_cnt
`endif
  );

  modport slave (
    input  in_valid, stall, flush, opcode, funct3, funct7_5, rs1, rs2, rd,
           rs1_data, rs2_data, imm, pc,
    output hazard, ex_valid, ex_a, ex_b, ex_op, ex_store_data, ex_rd, ex_pc,
           ex_regwrite, ex_memread, ex_memwrite, ex_beq, ex_bne, ex_illegal
`ifdef BUBBLE_CNT_EN
    , output bubble_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with yAlu op decode
// (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT), operand-B select and load-use hazard
// detection.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (clears every EX register)
//   bus    - id_ex_if.slave: ID-side inputs, stall/flush, hazard and ex_*
// Edge priority: reset > flush (bubble) > stall (hold) > hazard (bubble)
//   > in_valid=0 (bubble) > illegal (bubble + ex_illegal) > load.
// Optional build macro BUBBLE_CNT_EN adds bus.bubble_cnt, a saturating
// count of bubbles caused by flush, hazard or illegal instructions.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
);
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // Shared funct3 lookup for R-type and I-ALU: returns {legal, op}.
  function automatic logic [3:0] alu_f3(input logic [2:0] f3);
    logic [3:0] res;
    case (f3)
      3'b000:  res = {1'b1, ALU_ADD};
      3'b111:  res = {1'b1, ALU_AND};
      3'b110:  res = {1'b1, ALU_OR};
      3'b010:  res = {1'b1, ALU_SLT};
      default: res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_a;
  logic [XLEN-1:0] r_ex_b;
  logic [2:0]      r_ex_op;
  logic [XLEN-1:0] r_ex_store_data;
  logic [RA_W-1:0] r_ex_rd;
  logic [XLEN-1:0] r_ex_pc;
  logic            r_ex_regwrite;
  logic            r_ex_memread;
  logic            r_ex_memwrite;
  logic            r_ex_beq;
  logic            r_ex_bne;
  logic            r_ex_illegal;

  logic       w_legal;
  logic [2:0] w_op;
  logic       w_use_imm;
  logic       w_regwrite;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_beq;
  logic       w_bne;
  logic [3:0] w_f3;
  logic       w_hazard;
  logic       w_hold;
  logic       w_run;
  logic       w_take;
  logic       w_illegal;

  // Instruction decode: legality, ALU op, operand-B select and control bits.
  always_comb begin
    w_legal    = 1'b0;
    w_op       = ALU_AND;
    w_use_imm  = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_beq      = 1'b0;
    w_bne      = 1'b0;
    w_f3       = alu_f3(bus.funct3);
    case (bus.opcode)
      OPC_R: begin
        w_legal    = w_f3[3];
        // funct7[5] only selects SUB for funct3=000; other R ops ignore it.
        w_op       = (bus.funct3 == 3'b000 && bus.funct7_5) ? ALU_SUB : w_f3[2:0];
        w_regwrite = 1'b1;
      end
      OPC_I: begin
        w_legal    = w_f3[3];
        w_op       = w_f3[2:0];
        w_use_imm  = 1'b1;
        w_regwrite = 1'b1;
      end
      OPC_LW: begin
        w_legal    = (bus.funct3 == 3'b010);
        w_op       = ALU_ADD;
        w_use_imm  = 1'b1;
        w_memread  = 1'b1;
        w_regwrite = 1'b1;
      end
      OPC_SW: begin
        w_legal    = (bus.funct3 == 3'b010);
        w_op       = ALU_ADD;
        w_use_imm  = 1'b1;
        w_memwrite = 1'b1;
      end
      OPC_BR: begin
        w_op    = ALU_SUB;
        w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
        w_beq   = (bus.funct3 == 3'b000);
        w_bne   = (bus.funct3 == 3'b001);
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // rs2 is compared even for I-type; the occasional needless stall is accepted.
  assign w_hazard = r_ex_valid & r_ex_memread & (r_ex_rd != {RA_W{1'b0}}) & bus.in_valid &
                    ((r_ex_rd == bus.rs1) | (r_ex_rd == bus.rs2));

  assign w_hold    = ~bus.flush & bus.stall;
  assign w_run     = ~bus.flush & ~bus.stall & ~w_hazard & bus.in_valid;
  assign w_take    = w_run & w_legal;
  assign w_illegal = w_run & ~w_legal;

  // EX register: every non-load case writes a zeroed bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_a          <= {XLEN{1'b0}};
      r_ex_b          <= {XLEN{1'b0}};
      r_ex_op         <= 3'd0;
      r_ex_store_data <= {XLEN{1'b0}};
      r_ex_rd         <= {RA_W{1'b0}};
      r_ex_pc         <= {XLEN{1'b0}};
      r_ex_regwrite   <= 1'b0;
      r_ex_memread    <= 1'b0;
      r_ex_memwrite   <= 1'b0;
      r_ex_beq        <= 1'b0;
      r_ex_bne        <= 1'b0;
      r_ex_illegal    <= 1'b0;
    end else if (!w_hold) begin
      r_ex_valid      <= w_take;
      r_ex_a          <= w_take ? bus.rs1_data : {XLEN{1'b0}};
      r_ex_b          <= w_take ? (w_use_imm ? bus.imm : bus.rs2_data) : {XLEN{1'b0}};
      r_ex_op         <= w_take ? w_op : 3'd0;
      r_ex_store_data <= w_take ? bus.rs2_data : {XLEN{1'b0}};
      r_ex_rd         <= w_take ? bus.rd : {RA_W{1'b0}};
      r_ex_pc         <= w_take ? bus.pc : {XLEN{1'b0}};
      r_ex_regwrite   <= w_take & w_regwrite & (bus.rd != {RA_W{1'b0}});
      r_ex_memread    <= w_take & w_memread;
      r_ex_memwrite   <= w_take & w_memwrite;
      r_ex_beq        <= w_take & w_beq;
      r_ex_bne        <= w_take & w_bne;
      r_ex_illegal    <= w_illegal;
    end
  end

`ifdef BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;
  logic        w_cnt_inc;

  // in_valid=0 bubbles and stall holds are not counted.
  assign w_cnt_inc = bus.flush | (~bus.stall & (w_hazard | (bus.in_valid & ~w_legal)));

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= 16'h0000;
    end else if (w_cnt_inc && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'h0001;
    end
  end

  assign bus.bubble_cnt = r_bubble_cnt;
`endif

  assign bus.hazard        = w_hazard;
  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_a          = r_ex_a;
  assign bus.ex_b          = r_ex_b;
  assign bus.ex_op         = r_ex_op;
  assign bus.ex_store_data = r_ex_store_data;
  assign bus.ex_rd         = r_ex_rd;
  assign bus.ex_pc         = r_ex_pc;
  assign bus.ex_regwrite   = r_ex_regwrite;
  assign bus.ex_memread    = r_ex_memread;
  assign bus.ex_memwrite   = r_ex_memwrite;
  assign bus.ex_beq        = r_ex_beq;
  assign bus.ex_bne        = r_ex_bne;
  assign bus.ex_illegal    = r_ex_illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage. A table-driven model
// predicts the EX register every edge; a negedge process compares all outputs.
// Directed literal checks pin the model; a random phase follows.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_if #(.XLEN(32), .RA_W(5)) bus();
  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rw, mr, mw, beq, bne, ill;
    logic [15:0] cnt;
  } ex_t;

  // f7: 0 / 1 must match funct7_5, 2 = don't care
  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [1:0] f7;
    logic [2:0] op;
    logic       imm, rw, mr, mw, beq, bne;
  } rule_t;

  rule_t rules [13];
  ex_t   m;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  logic [6:0] opcs [6];

  initial begin
    rules[0]  = '{7'b0110011, 3'b000, 2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[1]  = '{7'b0110011, 3'b000, 2'd1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[2]  = '{7'b0110011, 3'b111, 2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[3]  = '{7'b0110011, 3'b110, 2'd2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[4]  = '{7'b0110011, 3'b010, 2'd2, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[5]  = '{7'b0010011, 3'b000, 2'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[6]  = '{7'b0010011, 3'b111, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[7]  = '{7'b0010011, 3'b110, 2'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[8]  = '{7'b0010011, 3'b010, 2'd2, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rules[9]  = '{7'b0000011, 3'b010, 2'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rules[10] = '{7'b0100011, 3'b010, 2'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rules[11] = '{7'b1100011, 3'b000, 2'd2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rules[12] = '{7'b1100011, 3'b001, 2'd2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
    opcs[3] = 7'b0100011; opcs[4] = 7'b1100011; opcs[5] = 7'b1111111;
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'h0001;
  endfunction

  function automatic logic model_hazard(input ex_t cur);
    return cur.valid && cur.mr && (cur.rd != 5'd0) && bus.in_valid &&
           ((cur.rd == bus.rs1) || (cur.rd == bus.rs2));
  endfunction

  function automatic ex_t model_next(input ex_t cur);
    ex_t n;
    bit  hit;
    n = '0;
    n.cnt = cur.cnt;
    hit = 1'b0;
    if (!rst_n) return '0;
    if (bus.flush) n.cnt = sat_inc(cur.cnt);
    else if (bus.stall) n = cur;
    else if (model_hazard(cur)) n.cnt = sat_inc(cur.cnt);
    else if (bus.in_valid) begin
      foreach (rules[i]) begin
        if (!hit && rules[i].opc == bus.opcode && rules[i].f3 == bus.funct3 &&
            (rules[i].f7 == 2'd2 || rules[i].f7 == {1'b0, bus.funct7_5})) begin
          hit     = 1'b1;
          n.valid = 1'b1;
          n.a     = bus.rs1_data;
          n.b     = rules[i].imm ? bus.imm : bus.rs2_data;
          n.op    = rules[i].op;
          n.sd    = bus.rs2_data;
          n.rd    = bus.rd;
          n.pc    = bus.pc;
          n.rw    = rules[i].rw && (bus.rd != 5'd0);
          n.mr    = rules[i].mr;
          n.mw    = rules[i].mw;
          n.beq   = rules[i].beq;
          n.bne   = rules[i].bne;
        end
      end
      if (!hit) begin
        n.ill = 1'b1;
        n.cnt = sat_inc(cur.cnt);
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("valid",  32'(bus.ex_valid),      32'(m.valid));
      cmp("a",      bus.ex_a,               m.a);
      cmp("b",      bus.ex_b,               m.b);
      cmp("op",     32'(bus.ex_op),         32'(m.op));
      cmp("sd",     bus.ex_store_data,      m.sd);
      cmp("rd",     32'(bus.ex_rd),         32'(m.rd));
      cmp("pc",     bus.ex_pc,              m.pc);
      cmp("rw",     32'(bus.ex_regwrite),   32'(m.rw));
      cmp("mr",     32'(bus.ex_memread),    32'(m.mr));
      cmp("mw",     32'(bus.ex_memwrite),   32'(m.mw));
      cmp("beq",    32'(bus.ex_beq),        32'(m.beq));
      cmp("bne",    32'(bus.ex_bne),        32'(m.bne));
      cmp("ill",    32'(bus.ex_illegal),    32'(m.ill));
      cmp("hazard", 32'(bus.hazard),        32'(model_hazard(m)));
`ifdef BUBBLE_CNT_EN
      cmp("cnt",    32'(bus.bubble_cnt),    32'(m.cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdx,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
    bus.in_valid = 1'b1;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.funct7_5 = f75;
    bus.rs1      = r1;
    bus.rs2      = r2;
    bus.rd       = rdx;
    bus.rs1_data = d1;
    bus.rs2_data = d2;
    bus.imm      = im;
    bus.pc       = $urandom;
  endtask

  task automatic rand_inputs();
    rst_n        = ($urandom_range(0, 49) != 0);
    bus.in_valid = ($urandom_range(0, 9) != 0);
    bus.stall    = ($urandom_range(0, 9) == 0);
    bus.flush    = ($urandom_range(0, 11) == 0);
    bus.opcode   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 5)];
    bus.funct3   = 3'($urandom);
    bus.funct7_5 = 1'($urandom);
    bus.rs1      = 5'($urandom_range(0, 7));
    bus.rs2      = 5'($urandom_range(0, 7));
    bus.rd       = 5'($urandom_range(0, 7));
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.imm      = $urandom;
    bus.pc       = $urandom;
  endtask

  initial begin
    rand_inputs();
    rst_n = 1'b0;
    tick();
    rand_inputs();
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    cmp("rst_valid",  32'(bus.ex_valid),   32'd0);
    cmp("rst_op",     32'(bus.ex_op),      32'd0);
    cmp("rst_ill",    32'(bus.ex_illegal), 32'd0);
    cmp("rst_a",      bus.ex_a,            32'd0);
    cmp("rst_hazard", 32'(bus.hazard),     32'd0);

    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd3, 32'd99);
    tick();
    cmp("add_op",    32'(bus.ex_op),       32'd2);
    cmp("add_a",     bus.ex_a,             32'd5);
    cmp("add_b",     bus.ex_b,             32'd3);
    cmp("add_rw",    32'(bus.ex_regwrite), 32'd1);
    cmp("add_valid", 32'(bus.ex_valid),    32'd1);
    bus.funct7_5 = 1'b1;
    tick();
    cmp("sub_op",    32'(bus.ex_op),       32'd6);

    set_instr(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd0, 32'd9, 32'd3, 32'hFFFF_FFFF);
    tick();
    cmp("addi_op",   32'(bus.ex_op),       32'd2);
    cmp("addi_b",    bus.ex_b,             32'hFFFF_FFFF);
    cmp("addi_rw",   32'(bus.ex_regwrite), 32'd0);

    set_instr(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd7, 32'd100, 32'd0, 32'd8);
    tick();
    cmp("lw_mr",     32'(bus.ex_memread),  32'd1);
    set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd7, 5'd3, 32'd10, 32'd20, 32'd0);
    #1;
    cmp("hz_same",   32'(bus.hazard),      32'd1);
    tick();
    cmp("hz_bubble", 32'(bus.ex_valid),    32'd0);
    cmp("hz_clear",  32'(bus.hazard),      32'd0);
    tick();
    cmp("held_valid", 32'(bus.ex_valid),   32'd1);
    cmp("held_rd",    32'(bus.ex_rd),      32'd3);
`ifdef BUBBLE_CNT_EN
    cmp("cnt_hz",     32'(bus.bubble_cnt), 32'd1);
`endif

    bus.stall = 1'b1;
    set_instr(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_rd",    32'(bus.ex_rd),    32'd3);
      cmp("stall_valid", 32'(bus.ex_valid), 32'd1);
    end
    bus.flush = 1'b1;
    tick();
    cmp("flush_valid", 32'(bus.ex_valid),  32'd0);
`ifdef BUBBLE_CNT_EN
    cmp("cnt_flush",   32'(bus.bubble_cnt), 32'd2);
`endif

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3);
    tick();
    cmp("ill_set",   32'(bus.ex_illegal),  32'd1);
    cmp("ill_valid", 32'(bus.ex_valid),    32'd0);
    set_instr(7'b1100011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'd3);
    tick();
    cmp("ill_clear", 32'(bus.ex_illegal),  32'd0);
    cmp("bne",       32'(bus.ex_bne),      32'd1);
    cmp("bne_op",    32'(bus.ex_op),       32'd6);
`ifdef BUBBLE_CNT_EN
    cmp("cnt_ill",   32'(bus.bubble_cnt),  32'd3);
`endif

    repeat (3000) begin
      rand_inputs();
      tick();
    end

`ifdef BUBBLE_CNT_EN
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    repeat (65540) tick();
    cmp("cnt_sat", 32'(bus.bubble_cnt), 32'h0000_FFFF);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
